// File: rtl/stall_pipeline_ctrl.sv
// stall_pipeline_ctrl: 3-stage valid/ready register pipeline with per-stage stall/flush, occupancy and transfer count
module stall_pipeline_ctrl #(
  parameter int WIDTH = 100,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  input  logic [2:0]       stall,
  input  logic [2:0]       flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [2:0] v_q, v_d, ev, in_v;
  logic en_0, en_1, en_2, leave_0, leave_1, leave_2;
  logic [WIDTH-1:0] d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
  logic [1:0] occupancy_q, occupancy_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  assign ev = v_q & ~flush;
  // a stalled stage neither loads nor releases, so leave also requires ~stall
  always_comb begin
    leave_2 = ev[2] & out_ready & ~stall[2];
    en_2 = ~stall[2] & ~flush[2] & (~ev[2] | leave_2);
    leave_1 = ev[1] & ~stall[1] & en_2;
    en_1 = ~stall[1] & ~flush[1] & (~ev[1] | leave_1);
    leave_0 = ev[0] & ~stall[0] & en_1;
    en_0 = ~stall[0] & ~flush[0] & (~ev[0] | leave_0);
    in_v = {ev[1:0], in_valid};
    v_d[0] = flush[0] ? 1'b0 : en_0 ? in_v[0] : leave_0 ? 1'b0 : v_q[0];
    v_d[1] = flush[1] ? 1'b0 : en_1 ? in_v[1] : leave_1 ? 1'b0 : v_q[1];
    v_d[2] = flush[2] ? 1'b0 : en_2 ? in_v[2] : leave_2 ? 1'b0 : v_q[2];
    d0_d = (en_0 & in_v[0]) ? datain : d0_q;
    d1_d = (en_1 & in_v[1]) ? d0_q : d1_q;
    d2_d = (en_2 & in_v[2]) ? d1_q : d2_q;
    occupancy_d = 2'(v_d[0]) + 2'(v_d[1]) + 2'(v_d[2]);
    xfer_cnt_d = xfer_cnt_q + CNT_W'(out_valid & out_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      occupancy_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      v_q <= v_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      occupancy_q <= occupancy_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end
  assign in_ready = en_0;
  assign out_valid = ev[2] & ~stall[2];
  assign dataout = d2_q;
  assign occupancy = occupancy_q;
  assign xfer_cnt = xfer_cnt_q;
endmodule
